// File: rtl/seq_pkg.sv
// Shared definitions for the seq_pattern_tx serial frame transmitter.
//   state_e         : FSM state encoding (IDLE, SHIFT, GAP, FIN)
//   DEFAULT_PATTERN : pattern held in the capture register out of reset
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [4:0] DEFAULT_PATTERN = 5'b10110;

endpackage : seq_pkg

// File: rtl/seq_piso.sv
// Loadable MSB-first parallel-in/serial-out shift register with bit counter.
//   clk, rst  : clock, async active-low reset
//   load_i    : load data_i and restart the bit counter
//   shift_i   : shift left by one (zero fill), advance counter modulo W
//   data_i    : parallel frame, MSB transmitted first
//   msb_o     : current serial bit (register MSB)
//   last_o    : current bit is the last one of the frame
module seq_piso #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o,
  output logic         last_o
);

  localparam int unsigned BC_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]    sreg_q, sreg_d;
  logic [BC_W-1:0] cnt_q, cnt_d;

  assign msb_o  = sreg_q[W-1];
  assign last_o = (cnt_q == BC_W'(W - 1));

  // Load wins over shift; shifting out the last bit leaves the register zero.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sreg_d = data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      sreg_d = sreg_q << 1;
      cnt_d  = last_o ? '0 : cnt_q + BC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : seq_piso

// File: rtl/seq_pattern_tx.sv
// Repeating serial pattern transmitter: sends a captured SEQ_LEN-bit frame
// MSB first, reps times, with gap idle cycles between frames, then pulses done.
// Optional feature: define SEQ_TX_PARITY_EN to append an even-parity bit per frame.
//   clk, rst  : clock, async active-low reset
//   start     : request, accepted only while ready=1
//   pattern   : frame bits;  reps : frame count;  gap : idle cycles between frames
//   ready     : idle;  busy : ~ready
//   out_data  : serial bit;  out_valid : out_data carries a frame bit
//   done      : one-cycle pulse at request completion
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 5,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SEQ_LEN-1:0] pattern,
  input  logic [CNT_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               ready,
  output logic               out_data,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned FRAME_W = SEQ_LEN + 1;
`else
  localparam int unsigned FRAME_W = SEQ_LEN;
`endif

  state_e             state_q, state_d;
  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]   frames_q, frames_d, frames_dec;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               ready_q, busy_q, valid_q, done_q;

  logic               piso_load, piso_shift, piso_last;
  logic [FRAME_W-1:0] frame_new, frame_cap, load_data;

`ifdef SEQ_TX_PARITY_EN
  assign frame_new = {pattern, ^pattern};
  assign frame_cap = {pat_q, ^pat_q};
`else
  assign frame_new = pattern;
  assign frame_cap = pat_q;
`endif

  // Remaining-frame count saturates at zero.
  assign frames_dec = (frames_q != '0) ? frames_q - CNT_W'(1) : '0;

  seq_piso #(.W(FRAME_W)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .data_i  (load_data),
    .msb_o   (out_data),
    .last_o  (piso_last)
  );

  // Next-state, capture and shift-register control.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    frames_d   = frames_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    load_data  = frame_cap;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d    = pattern;
          gap_d    = gap;
          frames_d = reps;
          if (reps == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d   = ST_SHIFT;
            piso_load = 1'b1;
            load_data = frame_new;
          end
        end
      end
      ST_SHIFT: begin
        if (piso_last) begin
          frames_d = frames_dec;
          if (frames_dec == '0) begin
            state_d    = ST_FIN;
            piso_shift = 1'b1;
          end else if (gap_q == '0) begin
            piso_load = 1'b1;
          end else begin
            state_d    = ST_GAP;
            gap_cnt_d  = gap_q;
            piso_shift = 1'b1;
          end
        end else begin
          piso_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = ST_SHIFT;
          gap_cnt_d = '0;
          piso_load = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, capture registers and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= SEQ_LEN'(DEFAULT_PATTERN);
      frames_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      frames_q  <= frames_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      ready_q   <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
      valid_q   <= (state_d == ST_SHIFT);
      done_q    <= (state_d == ST_FIN);
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign done      = done_q;

endmodule : seq_pattern_tx

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx (default parameters).
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] pattern;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       ready, out_data, out_valid, busy, done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  seq_pattern_tx #(.SEQ_LEN(5), .CNT_W(4), .GAP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .reps      (reps),
    .gap       (gap),
    .ready     (ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, then record out_valid/out_data/done for cycles 1..ncyc
  // (cycle 1 ends up in bit ncyc-1). Inputs are scrambled after the accepting
  // edge; start is pulsed with junk inputs on cycle poke_cyc (0 = never).
  task automatic run_req(input logic [4:0] p, input logic [3:0] r, input logic [3:0] g,
                         input int ncyc, input int poke_cyc,
                         output logic [31:0] v, output logic [31:0] d,
                         output logic [31:0] dn);
    v = '0; d = '0; dn = '0;
    @(negedge clk);
    pattern = p; reps = r; gap = g; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; pattern = 5'b01001; reps = 4'd7; gap = 4'd3;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      v  = {v[30:0], out_valid};
      d  = {d[30:0], out_data};
      dn = {dn[30:0], done};
      start = (cyc == poke_cyc);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; pattern = '0; reps = '0; gap = '0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({ready, busy, out_valid, out_data, done} !== 5'b10000) begin
      $display("FAIL reset_outputs: got rdy/busy/vld/dat/done=%b want 10000",
               {ready, busy, out_valid, out_data, done});
    end else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] v, d, dn;
    run_req(DEFAULT_PATTERN, 4'd1, 4'd0, 6, 0, v, d, dn);
    chk_cnt++;
    if (v !== 32'b111110) begin
      $display("FAIL single_valid: got %b want 111110", v[5:0]);
    end else pass_cnt++;
    chk_cnt++;
    if (d !== 32'b101100) begin
      $display("FAIL single_data: got %b want 101100", d[5:0]);
    end else pass_cnt++;
    chk_cnt++;
    if (dn !== 32'b000001) begin
      $display("FAIL single_done: got %b want 000001", dn[5:0]);
    end else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({ready, busy, done} !== 3'b100) begin
      $display("FAIL single_idle_after: got rdy/busy/done=%b want 100", {ready, busy, done});
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, d, dn;
    logic [9:0]  stream;
    logic [4:0]  win;
    int          hits;
    int          nbits;
    stream = '0; win = '0; hits = 0; nbits = 0;
    run_req(5'b10110, 4'd2, 4'd0, 11, 0, v, d, dn);
    chk_cnt++;
    if (v !== 32'b11111111110) begin
      $display("FAIL b2b_valid: got %b want 11111111110", v[10:0]);
    end else pass_cnt++;
    // Collect valid bits and count 10110 hits with an overlapping window.
    for (int i = 10; i >= 0; i--) begin
      if (v[i]) begin
        stream = {stream[8:0], d[i]};
        win    = {win[3:0], d[i]};
        nbits++;
        if (nbits >= 5 && win == 5'b10110) hits++;
      end
    end
    chk_cnt++;
    if (stream !== 10'b1011010110) begin
      $display("FAIL b2b_stream: got %b want 1011010110", stream);
    end else pass_cnt++;
    chk_cnt++;
    if (hits !== 2) begin
      $display("FAIL b2b_detect: got %0d hits want 2", hits);
    end else pass_cnt++;
    chk_cnt++;
    if (dn !== 32'b00000000001) begin
      $display("FAIL b2b_done: got %b want 00000000001", dn[10:0]);
    end else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_gap();
    logic [31:0] v, d, dn;
    run_req(5'b11001, 4'd3, 4'd2, 20, 0, v, d, dn);
    chk_cnt++;
    if (v !== 32'b11111_00_11111_00_11111_0) begin
      $display("FAIL gap_valid: got %b want 11111001111100111110", v[19:0]);
    end else pass_cnt++;
    chk_cnt++;
    if (d !== 32'b11001_00_11001_00_11001_0) begin
      $display("FAIL gap_data: got %b want 11001001100100110010", d[19:0]);
    end else pass_cnt++;
    chk_cnt++;
    if (dn !== 32'd1) begin
      $display("FAIL gap_done: got %b want 00000000000000000001", dn[19:0]);
    end else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (ready !== 1'b1) begin
      $display("FAIL gap_idle_after: got ready=%b want 1", ready);
    end else pass_cnt++;
  endtask

  task automatic test_reps_zero();
    logic [31:0] v, d, dn;
    run_req(5'b10110, 4'd0, 4'd0, 1, 0, v, d, dn);
    chk_cnt++;
    if ({v[0], dn[0], ready, busy} !== 4'b0101) begin
      $display("FAIL zero_fin: got vld/done/rdy/busy=%b want 0101", {v[0], dn[0], ready, busy});
    end else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({out_valid, done, ready} !== 3'b001) begin
      $display("FAIL zero_idle: got vld/done/rdy=%b want 001", {out_valid, done, ready});
    end else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    logic [31:0] v, d, dn;
    logic [3:0]  late;
    late = '0;
    run_req(5'b10110, 4'd1, 4'd0, 6, 2, v, d, dn);
    chk_cnt++;
    if ({v[5:0], d[5:0], dn[5:0]} !== {6'b111110, 6'b101100, 6'b000001}) begin
      $display("FAIL ignore_trace: got v=%b d=%b done=%b want 111110 101100 000001",
               v[5:0], d[5:0], dn[5:0]);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      late[i] = out_valid | done | ~ready;
    end
    chk_cnt++;
    if (late !== 4'b0000) begin
      $display("FAIL ignore_no_restart: got activity=%b want 0000", late);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v, d, dn;
    logic        seen;
    seen = 1'b0;
    run_req(5'b10110, 4'd1, 4'd0, 3, 0, v, d, dn);
    chk_cnt++;
    if ({v[0], d[0]} !== 2'b11) begin
      $display("FAIL rstmid_third_bit: got vld/dat=%b want 11", {v[0], d[0]});
    end else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if ({ready, busy, out_valid, out_data, done} !== 5'b10000) begin
      $display("FAIL rstmid_async: got rdy/busy/vld/dat/done=%b want 10000",
               {ready, busy, out_valid, out_data, done});
    end else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || out_valid || !ready) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b0) begin
      $display("FAIL rstmid_no_done: got activity=%b want 0", seen);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reps_zero();
    test_start_ignored();
    test_reset_mid();
    test_single();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_seq_pattern_tx
